ebr_fifo_wr_arb: RTL

Round-robin write-port arbiter that lets NUM_CH independent valid/ready producers share the single write port of one `ebr_fifo`. Each grant holds for a burst of up to BURST beats. Every beat is tagged with the index of the channel that produced it. The fifo instance is sized to WIDTH+CH_W so the tag is stored alongside the data. The block sits directly in front of the fifo: `o_out_*` connects to the fifo input port, and `i_out_ready` connects to the fifo's `o_in_ready`.

---
 rtl/ebr_fifo_wr_arb.sv | 113 +++++++++++
 1 files changed

// File: rtl/ebr_fifo_wr_arb.sv
// Round-robin arbiter sharing one ebr_fifo write port among NUM_CH valid/ready producers.
// Each grant lasts up to BURST beats; every beat carries the producing channel index.
module ebr_fifo_wr_arb #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int BURST  = 8,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NUM_CH*WIDTH-1:0] i_in_data,
    input  logic [NUM_CH-1:0]       i_in_valid,
    output logic [NUM_CH-1:0]       o_in_ready,
    output logic [WIDTH-1:0]        o_out_data,
    output logic [CH_W-1:0]         o_out_chan,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [NUM_CH-1:0]       o_grant
);

    localparam int CNT_W = $clog2(BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  g, g_nxt;
    logic [CH_W-1:0]  ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             active;
    logic             g_valid;
    logic             xfer;
    logic             sel_found;
    logic [CH_W-1:0]  sel;

    // Reset masks the datapath so an in-flight beat cannot complete on the reset edge.
    assign active  = (state == GRANT) && !i_reset;
    assign g_valid = i_in_valid[g];
    assign xfer    = active && g_valid && i_out_ready;

    // Walk downward so the channel closest to ptr (upward, wrapping) is the last one written.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel       = '0;
        sel_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_in_valid[(int'(ptr) + i) % NUM_CH]) begin
                sel       = CH_W'((int'(ptr) + i) % NUM_CH);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = GRANT;
                    g_nxt     = sel;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!g_valid || (xfer && cnt == CNT_W'(BURST - 1))) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (g == CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
                end else if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and a reset sampled on the clock edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output mux is combinational from the registered grant; no data pipeline stage.
    always_comb begin
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_chan  = '0;
        o_in_ready  = '0;
        o_grant     = '0;
        if (active) begin
            o_out_valid   = g_valid;
            o_out_data    = i_in_data[int'(g)*WIDTH +: WIDTH];
            o_out_chan    = g;
            o_in_ready[g] = i_out_ready;
            o_grant[g]    = 1'b1;
        end
    end

endmodule
